// File: rtl/wb_copy_master.sv
// -----------------------------------------------------------------------------
// wb_copy_master
//
// Wishbone classic-cycle initiator that copies a block of 32-bit words from a
// source address range to a destination address range on the same bus. Each
// word is moved as one read cycle followed by one write cycle. An idle gap
// cycle follows every acknowledged access, so a slave that acks on
// (valid & !ack) never sees back-to-back strobes.
//
// Optional feature macro: WB_COPY_TIMEOUT_EN
//   defined   : ack wait counter; after TIMEOUT_CYCLES strobe cycles without
//               ack the copy is aborted, err_o is set and done_o pulses.
//   undefined : the master waits for ack indefinitely and err_o is tied 0.
//
// Parameters:
//   LEN_WIDTH       width of the word-count fields
//   TIMEOUT_CYCLES  ack wait limit (only meaningful with WB_COPY_TIMEOUT_EN)
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   start_i              one-cycle request, honoured only when idle
//   src_adr_i, dst_adr_i byte addresses, bits [1:0] ignored
//   len_i                number of words to copy
//   busy_o               high from the cycle after an accepted start through
//                        the done_o cycle
//   done_o               one-cycle completion pulse
//   err_o                timeout flag, held until the next accepted start
//   count_o              words fully written in the current/last copy
//   wbm_*                Wishbone master port (cyc == stb, sel = F while stb)
// -----------------------------------------------------------------------------
module wb_copy_master #(
    parameter int LEN_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] count_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RGAP = 3'd2,
        WR   = 3'd3,
        WGAP = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            srcAdr_q, srcAdr_d;
    logic [31:0]            dstAdr_q, dstAdr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [31:0]            data_q, data_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                   err_q, err_d;
    logic [TW-1:0]          waitCnt_q, waitCnt_d;
    logic                   timeoutHit;

    // The last allowed strobe cycle without ack is the one where the
    // counter already holds TIMEOUT_CYCLES-1.
    assign timeoutHit = (waitCnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0]            unusedTimeout;
    assign unusedTimeout = TIMEOUT_CYCLES;
`endif

    // Byte-lane bits of the addresses are deliberately discarded.
    logic unusedAdrBits;
    assign unusedAdrBits = ^{src_adr_i[1:0], dst_adr_i[1:0]};

    // State register plus the registered copy of every output.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            srcAdr_q  <= '0;
            dstAdr_q  <= '0;
            len_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
            err_q     <= 1'b0;
            waitCnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            srcAdr_q  <= srcAdr_d;
            dstAdr_q  <= dstAdr_d;
            len_q     <= len_d;
            count_q   <= count_d;
            data_q    <= data_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef WB_COPY_TIMEOUT_EN
            err_q     <= err_d;
            waitCnt_q <= waitCnt_d;
`endif
        end
    end

    // Next-state logic. The source/destination registers hold the address of
    // the current word and advance by one word after each acknowledged write,
    // wrapping modulo 2^32.
    always_comb begin
        state_d  = state_q;
        srcAdr_d = srcAdr_q;
        dstAdr_d = dstAdr_q;
        len_d    = len_q;
        count_d  = count_q;
        data_d   = data_q;
`ifdef WB_COPY_TIMEOUT_EN
        err_d     = err_q;
        // Cleared everywhere except while waiting, so every entry into RD or
        // WR starts from zero.
        waitCnt_d = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    srcAdr_d = {src_adr_i[31:2], 2'b00};
                    dstAdr_d = {dst_adr_i[31:2], 2'b00};
                    len_d    = len_i;
                    count_d  = '0;
`ifdef WB_COPY_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = (len_i == '0) ? DONE : RD;
                end
            end

            RD: begin
                if (wbm_ack_i) begin
                    data_d  = wbm_dat_i;
                    state_d = RGAP;
                end
`ifdef WB_COPY_TIMEOUT_EN
                else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end

            RGAP: begin
                state_d = WR;
            end

            WR: begin
                if (wbm_ack_i) begin
                    count_d  = count_q + 1'b1;
                    srcAdr_d = srcAdr_q + 32'd4;
                    dstAdr_d = dstAdr_q + 32'd4;
                    state_d  = WGAP;
                end
`ifdef WB_COPY_TIMEOUT_EN
                else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end

            WGAP: begin
                state_d = (count_q == len_q) ? DONE : RD;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode works on the next state so that the registered outputs
    // line up with the state they describe (no extra cycle of latency).
    always_comb begin
        cyc_d  = (state_d == RD) || (state_d == WR);
        we_d   = (state_d == WR);
        adr_d  = '0;
        if (state_d == RD) begin
            adr_d = srcAdr_d;
        end else if (state_d == WR) begin
            adr_d = dstAdr_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign count_o   = count_q;

`ifdef WB_COPY_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_copy_master.sv
// -----------------------------------------------------------------------------
// tb_wb_copy_master
//
// Directed bench for wb_copy_master. A behavioural Wishbone slave answers
// reads after two strobe cycles and writes after one, serving reads from
// srcMem and storing writes into dstMem (both word-indexed by adr[11:2]).
// Each scenario task drives its own stimulus and compares against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_wb_copy_master;

    localparam int LW        = 10;
    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [31:0]    srcAdr;
    logic [31:0]    dstAdr;
    logic [LW-1:0]  len;

    logic           busy_o, done_o, err_o;
    logic [LW-1:0]  count_o;
    logic           wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]     wbm_sel_o;
    logic [31:0]    wbm_adr_o, wbm_dat_o;
    logic [31:0]    slaveDat;
    logic           slaveAck;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    wb_copy_master #(
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start),
        .src_adr_i (srcAdr),
        .dst_adr_i (dstAdr),
        .len_i     (len),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .count_o   (count_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (slaveDat),
        .wbm_ack_i (slaveAck)
    );

    // Slave model: memories, ack generation and access logs.
    logic [31:0] srcMem [0:1023];
    logic [31:0] dstMem [0:1023];
    logic [31:0] rdLog [$];
    logic [31:0] wrLog [$];
    int stbCnt = 0;
    int wrAcks = 0;
    int wrAckLimit = 32'h3FFFFFFF;
    int cycleNo = 0;
    int cycCount = 0;
    int sampEdge = 0;

    assign slaveDat = srcMem[wbm_adr_o[11:2]];
    assign slaveAck = wbm_cyc_o && wbm_stb_o
                      && (!wbm_we_o || (wrAcks < wrAckLimit))
                      && (stbCnt == ((wbm_we_o ? WRITE_LAT : READ_LAT) - 1));

    always @(posedge clk) begin
        cycleNo <= cycleNo + 1;
        if (wbm_cyc_o) cycCount <= cycCount + 1;
        if (wbm_stb_o && !slaveAck) stbCnt <= stbCnt + 1;
        else stbCnt <= 0;
        if (wbm_stb_o && slaveAck) begin
            if (wbm_we_o) begin
                dstMem[wbm_adr_o[11:2]] <= wbm_dat_o;
                wrLog.push_back(wbm_adr_o);
                wrAcks <= wrAcks + 1;
            end else begin
                rdLog.push_back(wbm_adr_o);
            end
        end
    end

    // Pulses start for one cycle; returns on the falling edge right after the
    // sampling edge, which is where busy_o first shows.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                 input logic [LW-1:0] n);
        @(negedge clk);
        start  = 1'b1;
        srcAdr = s;
        dstAdr = d;
        len    = n;
        @(negedge clk);
        start  = 1'b0;
        sampEdge = cycleNo;
    endtask

    // Waits (bounded) for done_o; lat is edges after the sampling edge, -1 on
    // expiry. With Lr=2, Lw=1 each word costs 5 cycles, so lat = 5*len.
    task automatic waitDone(input int limit, output int lat);
        lat = -1;
        for (int n = 0; n < limit && lat < 0; n++) begin
            if (done_o) lat = cycleNo - sampEdge;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        srcAdr = '0;
        dstAdr = '0;
        len = '0;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b0)
            $display("[TB] FAIL reset_bus: got %b expected %b", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'b0);
        else passCount++;
        checkCount++;
        if ({busy_o, done_o, err_o} !== 3'b000)
            $display("[TB] FAIL reset_status: got %b expected 000", {busy_o, done_o, err_o});
        else passCount++;
        checkCount++;
        if ({wbm_adr_o, wbm_dat_o, count_o} !== '0)
            $display("[TB] FAIL reset_data: adr %h dat %h count %0d expected all 0", wbm_adr_o, wbm_dat_o, count_o);
        else passCount++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_copy();
        int lat;
        int rdBase;
        int wrBase;
        for (int j = 0; j < 4; j++) srcMem[32'h40 + j] = 32'hA0 + j;
        rdBase = rdLog.size();
        wrBase = wrLog.size();
        applyStimulus(32'h100, 32'h800, 10'd4);
        checkCount++;
        if ({busy_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 8'b1110_1111)
            $display("[TB] FAIL basic_first_cycle: got %b expected 11101111", {busy_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
        else passCount++;
        checkCount++;
        if (wbm_adr_o !== 32'h100)
            $display("[TB] FAIL basic_first_adr: got %h expected 00000100", wbm_adr_o);
        else passCount++;
        waitDone(200, lat);
        checkCount++;
        if (lat != 20) $display("[TB] FAIL basic_latency: got %0d expected 20", lat);
        else passCount++;
        checkCount++;
        if ({busy_o, err_o, count_o} !== {1'b1, 1'b0, 10'd4})
            $display("[TB] FAIL basic_done_status: busy %b err %b count %0d expected 1 0 4", busy_o, err_o, count_o);
        else passCount++;
        checkCount++;
        if ((rdLog.size() - rdBase != 4) || (wrLog.size() - wrBase != 4))
            $display("[TB] FAIL basic_access_count: reads %0d writes %0d expected 4 4", rdLog.size() - rdBase, wrLog.size() - wrBase);
        else passCount++;
        for (int j = 0; j < 4; j++) begin
            checkCount++;
            if (rdLog[rdBase + j] !== 32'h100 + 4 * j || wrLog[wrBase + j] !== 32'h800 + 4 * j)
                $display("[TB] FAIL basic_adr_%0d: rd %h wr %h expected %h %h", j, rdLog[rdBase + j], wrLog[wrBase + j], 32'h100 + 4 * j, 32'h800 + 4 * j);
            else passCount++;
            checkCount++;
            if (dstMem[32'h200 + j] !== 32'hA0 + j)
                $display("[TB] FAIL basic_data_%0d: got %h expected %h", j, dstMem[32'h200 + j], 32'hA0 + j);
            else passCount++;
        end
        @(negedge clk);
        checkCount++;
        if ({busy_o, done_o} !== 2'b00)
            $display("[TB] FAIL basic_after_done: busy/done %b expected 00", {busy_o, done_o});
        else passCount++;
    endtask

    task automatic test_zero_len();
        int cycBase;
        cycBase = cycCount;
        applyStimulus(32'h100, 32'h800, 10'd0);
        checkCount++;
        if ({done_o, busy_o, wbm_cyc_o, count_o} !== {1'b1, 1'b1, 1'b0, 10'd0})
            $display("[TB] FAIL zero_done: done %b busy %b cyc %b count %0d expected 1 1 0 0", done_o, busy_o, wbm_cyc_o, count_o);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({done_o, busy_o} !== 2'b00 || cycCount != cycBase)
            $display("[TB] FAIL zero_after: done/busy %b cyc cycles %0d expected 00 0", {done_o, busy_o}, cycCount - cycBase);
        else passCount++;
    endtask

    task automatic test_wrap();
        int lat;
        int rdBase;
        logic [31:0] expRd [3];
        expRd = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        srcMem[10'h3FE] = 32'hB0;
        srcMem[10'h3FF] = 32'hB1;
        srcMem[10'h000] = 32'hB2;
        rdBase = rdLog.size();
        applyStimulus(32'hFFFF_FFFB, 32'h400, 10'd3);
        waitDone(200, lat);
        checkCount++;
        if (lat != 15 || count_o !== 10'd3)
            $display("[TB] FAIL wrap_done: latency %0d count %0d expected 15 3", lat, count_o);
        else passCount++;
        for (int j = 0; j < 3; j++) begin
            checkCount++;
            if (rdLog[rdBase + j] !== expRd[j] || dstMem[32'h100 + j] !== 32'hB0 + j)
                $display("[TB] FAIL wrap_word_%0d: rd adr %h data %h expected %h %h", j, rdLog[rdBase + j], dstMem[32'h100 + j], expRd[j], 32'hB0 + j);
            else passCount++;
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int rdBase;
        int wrBase;
        for (int j = 0; j < 4; j++) srcMem[32'h80 + j] = 32'hC0 + j;
        rdBase = rdLog.size();
        wrBase = wrLog.size();
        applyStimulus(32'h200, 32'hC00, 10'd4);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        srcAdr = 32'h600;
        dstAdr = 32'hE00;
        len    = 10'd2;
        @(negedge clk);
        start  = 1'b0;
        waitDone(200, lat);
        checkCount++;
        if (lat != 20 || count_o !== 10'd4)
            $display("[TB] FAIL ignore_done: latency %0d count %0d expected 20 4", lat, count_o);
        else passCount++;
        checkCount++;
        if ((rdLog.size() - rdBase != 4) || (wrLog.size() - wrBase != 4))
            $display("[TB] FAIL ignore_access_count: reads %0d writes %0d expected 4 4", rdLog.size() - rdBase, wrLog.size() - wrBase);
        else passCount++;
        for (int j = 0; j < 4; j++) begin
            checkCount++;
            if (rdLog[rdBase + j] !== 32'h200 + 4 * j || wrLog[wrBase + j] !== 32'hC00 + 4 * j || dstMem[32'h300 + j] !== 32'hC0 + j)
                $display("[TB] FAIL ignore_word_%0d: rd %h wr %h data %h expected %h %h %h", j, rdLog[rdBase + j], wrLog[wrBase + j], dstMem[32'h300 + j], 32'h200 + 4 * j, 32'hC00 + 4 * j, 32'hC0 + j);
            else passCount++;
        end
        repeat (3) @(negedge clk);
        checkCount++;
        if ({busy_o, wbm_cyc_o} !== 2'b00)
            $display("[TB] FAIL ignore_no_restart: busy/cyc %b expected 00", {busy_o, wbm_cyc_o});
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit found;
        found = 1'b0;
        applyStimulus(32'h100, 32'hA00, 10'd4);
        for (int n = 0; n < 200 && !found; n++) begin
            if (wbm_cyc_o && wbm_we_o && count_o == 10'd2) found = 1'b1;
            else @(negedge clk);
        end
        checkCount++;
        if (!found) $display("[TB] FAIL rstmid_reach_wr2: got not reached expected reached");
        else passCount++;
        rst = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o} !== 9'b0)
            $display("[TB] FAIL rstmid_outputs: got %b expected 000000000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o});
        else passCount++;
        checkCount++;
        if (count_o !== 10'd0) $display("[TB] FAIL rstmid_count: got %0d expected 0", count_o);
        else passCount++;
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(32'h100, 32'hB00, 10'd2);
        waitDone(200, lat);
        checkCount++;
        if (lat != 10 || count_o !== 10'd2)
            $display("[TB] FAIL rstmid_rerun: latency %0d count %0d expected 10 2", lat, count_o);
        else passCount++;
        checkCount++;
        if (dstMem[32'h2C0] !== 32'hA0 || dstMem[32'h2C1] !== 32'hA1)
            $display("[TB] FAIL rstmid_rerun_data: got %h %h expected a0 a1", dstMem[32'h2C0], dstMem[32'h2C1]);
        else passCount++;
        @(negedge clk);
    endtask

`ifdef WB_COPY_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        int stbLen;
        bit found;
        found = 1'b0;
        stbLen = 0;
        wrAckLimit = wrAcks + 1;
        applyStimulus(32'h100, 32'hD00, 10'd3);
        for (int n = 0; n < 200 && !found; n++) begin
            if (wbm_stb_o && wbm_we_o && count_o == 10'd1) found = 1'b1;
            else @(negedge clk);
        end
        for (int n = 0; n < 50 && wbm_stb_o; n++) begin
            stbLen++;
            @(negedge clk);
        end
        checkCount++;
        if (!found || stbLen != 8)
            $display("[TB] FAIL timeout_stb_len: reached %0d stb cycles %0d expected 1 8", found, stbLen);
        else passCount++;
        checkCount++;
        if ({done_o, err_o, count_o} !== {1'b1, 1'b1, 10'd1})
            $display("[TB] FAIL timeout_done: done %b err %b count %0d expected 1 1 1", done_o, err_o, count_o);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({busy_o, err_o} !== 2'b01)
            $display("[TB] FAIL timeout_err_hold: busy/err %b expected 01", {busy_o, err_o});
        else passCount++;
        wrAckLimit = 32'h3FFFFFFF;
        applyStimulus(32'h100, 32'hD00, 10'd1);
        checkCount++;
        if (err_o !== 1'b0) $display("[TB] FAIL timeout_err_clear: got %b expected 0", err_o);
        else passCount++;
        waitDone(200, lat);
        checkCount++;
        if (lat != 5 || err_o !== 1'b0)
            $display("[TB] FAIL timeout_rerun: latency %0d err %b expected 5 0", lat, err_o);
        else passCount++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
`ifdef WB_COPY_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
